// File: rtl/puf_pkg.sv
// Shared constants for the response-voting block: FSM state encoding and
// default geometry (word width, evaluations per challenge).
package puf_pkg;

  localparam int DEFAULT_DATA_W   = 32;
  localparam int DEFAULT_NUM_EVAL = 15;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ACCUM   = 2'd1;
  localparam logic [1:0] ST_COMPUTE = 2'd2;
  localparam logic [1:0] ST_OUT     = 2'd3;

endpackage

// File: rtl/rsp_vote_if.sv
// Bundles the sample input stream, the voted-result output stream and the
// run control/status of rsp_vote.
interface rsp_vote_if #(
  parameter int DATA_W = 32
);
  localparam int UC_W = $clog2(DATA_W + 1);

  // Both streams use valid/ready: a transfer happens on a rising clk edge where
  // valid && ready; the producer holds data stable while valid && !ready and
  // never waits on ready before raising valid.
  logic              start;
  logic              in_valid;
  logic [DATA_W-1:0] in_write;
  logic [DATA_W-1:0] in_clean;
  logic              in_ready;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_rsp;
  logic [DATA_W-1:0] out_unstable;
  logic [UC_W-1:0]   out_unstable_cnt;
  logic              busy;

  modport master (
    output start, in_valid, in_write, in_clean, out_ready,
    input  in_ready, out_valid, out_rsp, out_unstable, out_unstable_cnt, busy
  );

  modport slave (
    input  start, in_valid, in_write, in_clean, out_ready,
    output in_ready, out_valid, out_rsp, out_unstable, out_unstable_cnt, busy
  );

endinterface

// File: rtl/rsp_vote_popcnt.sv
// Purely combinational population count of a DATA_W-bit word.
module popcnt #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = $clog2(DATA_W + 1)
) (
  input  logic [DATA_W-1:0] data_i,
  output logic [CNT_W-1:0]  cnt_o
);

  logic [CNT_W-1:0] acc;

  always_comb begin
    acc = '0;
    for (int i = 0; i < DATA_W; i++) begin
      acc = acc + CNT_W'(data_i[i]);
    end
  end

  assign cnt_o = acc;

endmodule

// File: rtl/rsp_vote.sv
// Majority vote over NUM_EVAL (write XOR clean) samples per challenge, with a
// per-bit instability mask and its popcount.
module rsp_vote
  import puf_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int NUM_EVAL = DEFAULT_NUM_EVAL
) (
  input  logic       clk,
  input  logic       rst,
  rsp_vote_if.slave  bus,
  output logic [1:0] dbg_state_o
);

  localparam int CNT_W = $clog2(NUM_EVAL + 1);
  localparam int UC_W  = $clog2(DATA_W + 1);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q [DATA_W];
  logic [CNT_W-1:0]  cnt_d [DATA_W];
  logic [CNT_W-1:0]  smp_q, smp_d;
  logic [DATA_W-1:0] rsp_q, unst_q;
  logic [UC_W-1:0]   ucnt_q;

  logic [DATA_W-1:0] sample;
  logic              accept;
  logic [DATA_W-1:0] rsp_c, unst_c;
  logic [UC_W-1:0]   ucnt_c;

  assign sample = bus.in_write ^ bus.in_clean;
  assign accept = bus.in_valid && bus.in_ready;

  always_comb begin
    state_d = state_q;
    smp_d   = smp_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_ACCUM;
          smp_d   = '0;
          for (int i = 0; i < DATA_W; i++) cnt_d[i] = '0;
        end
      end
      ST_ACCUM: begin
        if (accept) begin
          for (int i = 0; i < DATA_W; i++) cnt_d[i] = cnt_q[i] + CNT_W'(sample[i]);
          smp_d = smp_q + CNT_W'(1);
          if (smp_q == CNT_W'(NUM_EVAL - 1)) state_d = ST_COMPUTE;
        end
      end
      ST_COMPUTE: state_d = ST_OUT;
      ST_OUT: begin
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A bit is stable only when every evaluation agreed (all zero or all one).
  always_comb begin
    rsp_c  = '0;
    unst_c = '0;
    for (int i = 0; i < DATA_W; i++) begin
      rsp_c[i]  = cnt_q[i] > CNT_W'(NUM_EVAL / 2);
      unst_c[i] = (cnt_q[i] != '0) && (cnt_q[i] != CNT_W'(NUM_EVAL));
    end
  end

  popcnt #(
    .DATA_W (DATA_W),
    .CNT_W  (UC_W)
  ) u_popcnt (
    .data_i (unst_c),
    .cnt_o  (ucnt_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      smp_q   <= '0;
      for (int i = 0; i < DATA_W; i++) cnt_q[i] <= '0;
      rsp_q   <= '0;
      unst_q  <= '0;
      ucnt_q  <= '0;
    end else begin
      state_q <= state_d;
      smp_q   <= smp_d;
      cnt_q   <= cnt_d;
      // Results are held outside COMPUTE so IDLE still shows the last vote.
      if (state_q == ST_COMPUTE) begin
        rsp_q  <= rsp_c;
        unst_q <= unst_c;
        ucnt_q <= ucnt_c;
      end
    end
  end

  assign bus.in_ready         = (state_q == ST_ACCUM);
  assign bus.out_valid        = (state_q == ST_OUT);
  assign bus.busy             = (state_q != ST_IDLE);
  assign bus.out_rsp          = rsp_q;
  assign bus.out_unstable     = unst_q;
  assign bus.out_unstable_cnt = ucnt_q;
  assign dbg_state_o          = state_q;

endmodule

// File: tb/tb_rsp_vote.sv
// Directed scoreboard bench for rsp_vote: drivers push expected votes, a
// negedge monitor pops and compares on every output handshake.
module tb_rsp_vote;

  localparam int DW    = 32;
  localparam int NE    = 15;
  localparam int UCW   = $clog2(DW + 1);
  localparam int EXP_W = 2 * DW + UCW;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] dbg_state;

  rsp_vote_if #(.DATA_W(DW)) bus ();

  rsp_vote #(
    .DATA_W   (DW),
    .NUM_EVAL (NE)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_tests  = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int acc_n    = 0;
  int last_acc = -100;

  logic [EXP_W-1:0] exp_q[$];

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic             prev_ov = 1'b0;
  logic             prev_hs = 1'b0;
  logic [EXP_W-1:0] prev_out;

  always @(negedge clk) begin
    logic [EXP_W-1:0] cur;
    logic [EXP_W-1:0] e;
    cyc++;
    cur = {bus.out_rsp, bus.out_unstable, bus.out_unstable_cnt};
    if (rst) begin
      acc_n   = 0;
      prev_ov = 1'b0;
      prev_hs = 1'b0;
    end else begin
      if (!bus.busy && bus.start) acc_n = 0;
      if (bus.in_valid && bus.in_ready) begin
        acc_n++;
        if (acc_n == NE) last_acc = cyc;
      end
      if (prev_ov && !prev_hs) begin
        check("valid_hold", 96'(bus.out_valid), 96'd1);
        if (bus.out_valid) check("out_stable", 96'(cur), 96'(prev_out));
      end
      if (bus.out_valid && !prev_ov) check("latency", 96'(cyc), 96'(last_acc + 2));
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_out: got result %0h expected none (cycle %0d)", cur, cyc);
        end else begin
          e = exp_q.pop_front();
          check("out_rsp",          96'(bus.out_rsp),          96'(e[EXP_W-1 -: DW]));
          check("out_unstable",     96'(bus.out_unstable),     96'(e[UCW +: DW]));
          check("out_unstable_cnt", 96'(bus.out_unstable_cnt), 96'(e[UCW-1:0]));
        end
      end
      prev_ov  = bus.out_valid;
      prev_hs  = bus.out_valid && bus.out_ready;
      prev_out = cur;
    end
  end

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic send_sample(input logic [DW-1:0] s, input bit gaps);
    logic [DW-1:0] c;
    bit            rdy;
    int            n;
    if (gaps) begin
      repeat ($urandom_range(0, 3)) begin
        bus.in_write = $urandom;
        bus.in_clean = $urandom;
        tick();
      end
    end
    c            = $urandom;
    bus.in_write = s ^ c;
    bus.in_clean = c;
    bus.in_valid = 1'b1;
    n            = 0;
    do begin
      rdy = bus.in_ready;
      tick();
      n++;
    end while (!rdy && n < 20);
    if (!rdy) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: got in_ready 0 for %0d cycles expected 1", n);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic run_vote(input logic [DW-1:0] sa, input int na, input logic [DW-1:0] sb,
                          input bit alt, input bit gaps, input logic [DW-1:0] e_rsp,
                          input logic [DW-1:0] e_unst, input int e_cnt);
    exp_q.push_back({e_rsp, e_unst, UCW'(e_cnt)});
    do_start();
    for (int i = 0; i < NE; i++) begin
      if (alt) send_sample((i % 2 == 0) ? sa : sb, gaps);
      else     send_sample((i < na) ? sa : sb, gaps);
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    check("drain", 96'(exp_q.size()), 96'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_write  = '0;
    bus.in_clean  = '0;
    bus.out_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy",      96'(bus.busy),             96'd0);
    check("rst_out_valid", 96'(bus.out_valid),        96'd0);
    check("rst_in_ready",  96'(bus.in_ready),         96'd0);
    check("rst_rsp",       96'(bus.out_rsp),          96'd0);
    check("rst_unst",      96'(bus.out_unstable),     96'd0);
    check("rst_cnt",       96'(bus.out_unstable_cnt), 96'd0);
    check("rst_state",     96'(dbg_state),            96'd0);
    tick();

    // All evaluations flip every bit: stable ones.
    run_vote(32'hFFFF_FFFF, 15, 32'h0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0, 0);
    wait_drain();
    // 8 vs 7 on bit 0, then 7 vs 8.
    run_vote(32'h0000_0001, 8, 32'h0, 1'b0, 1'b0, 32'h0000_0001, 32'h0000_0001, 1);
    wait_drain();
    run_vote(32'h0000_0001, 7, 32'h0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0001, 1);
    wait_drain();

    // Consumer stalls in OUT; stray in_valid and start must be ignored.
    bus.out_ready = 1'b0;
    run_vote(32'h0000_00F0, 10, 32'h0, 1'b0, 1'b0, 32'h0000_00F0, 32'h0000_00F0, 4);
    n = 0;
    while (!bus.out_valid && n < 20) begin
      tick();
      n++;
    end
    check("stall_out_valid", 96'(bus.out_valid), 96'd1);
    for (int k = 0; k < 10; k++) begin
      bus.in_valid = k[0];
      bus.in_write = $urandom;
      bus.in_clean = $urandom;
      bus.start    = (k == 3 || k == 7);
      @(negedge clk);
      check("stall_in_ready", 96'(bus.in_ready), 96'd0);
      check("stall_busy",     96'(bus.busy),     96'd1);
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.start     = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    bus.start     = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    check("post_hs_busy",      96'(bus.busy),             96'd0);
    check("post_hs_out_valid", 96'(bus.out_valid),        96'd0);
    check("idle_keep_rsp",     96'(bus.out_rsp),          96'h0000_00F0);
    check("idle_keep_unst",    96'(bus.out_unstable),     96'h0000_00F0);
    check("idle_keep_cnt",     96'(bus.out_unstable_cnt), 96'd4);
    repeat (3) tick();
    @(negedge clk);
    check("start_with_hs_ignored", 96'(bus.busy), 96'd0);
    tick();
    bus.out_ready = 1'b1;
    check("drain_stall", 96'(exp_q.size()), 96'd0);

    // Reset mid-run discards the partial vote.
    do_start();
    for (int i = 0; i < 5; i++) send_sample($urandom, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_busy",      96'(bus.busy),             96'd0);
    check("mid_rst_out_valid", 96'(bus.out_valid),        96'd0);
    check("mid_rst_rsp",       96'(bus.out_rsp),          96'd0);
    check("mid_rst_unst",      96'(bus.out_unstable),     96'd0);
    check("mid_rst_cnt",       96'(bus.out_unstable_cnt), 96'd0);
    check("mid_rst_state",     96'(dbg_state),            96'd0);
    repeat (5) tick();
    @(negedge clk);
    check("no_result_after_rst", 96'(bus.out_valid), 96'd0);
    tick();
    run_vote(32'h0, 15, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 0);
    wait_drain();

    // Alternating patterns with random input gaps: every bit unstable.
    run_vote(32'hAAAA_AAAA, 0, 32'h5555_5555, 1'b1, 1'b1, 32'hAAAA_AAAA, 32'hFFFF_FFFF, 32);
    wait_drain();

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: got no completion expected finish before 200000 ns");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
